// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity modes.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync2 (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge gclk) begin
    if (!grst_n) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end

  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver: configurable data width, parity and stop bits,
// with parity, framing and break status latched per frame.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DLAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_SLAST = IW'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_rx_cfg: CLKS_PER_BIT out of range 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_cfg: DATA_BITS out of range 5..9");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_par
      $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic rx;

  uart_sync2 u_sync (
    .gclk   (i_Clock),
    .grst_n (i_Rst_L),
    .d      (i_Rx_Serial),
    .q      (rx)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic [1:0]           settle_q, settle_d;
  logic                 arm_q, arm_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 frm_q, frm_d;
  logic                 brk_q, brk_d;
  logic                 ferr_now, par_x;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    ferr_d   = ferr_q;
    dv_d     = 1'b0;
    byte_d   = byte_q;
    perr_d   = perr_q;
    frm_d    = frm_q;
    brk_d    = brk_q;
    ferr_now = ferr_q | ~rx;
    par_x    = (^shift_q) ^ par_q;
    // The synchronizer reads 1 for two cycles after reset; only a line seen
    // high after that arms the start detector, so a line already low at
    // release does not start a frame.
    settle_d = {settle_q[0], 1'b1};
    arm_d    = arm_q | (settle_q[1] & rx);

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        if (arm_q && !rx) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_DLAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_SLAST) begin
            // Frame ends at the centre of the last stop bit so a start edge
            // half a bit later is caught from IDLE.
            idx_d   = '0;
            dv_d    = 1'b1;
            byte_d  = shift_q;
            perr_d  = (PARITY_MODE == PAR_EVEN) ? par_x :
                      (PARITY_MODE == PAR_ODD)  ? ~par_x : 1'b0;
            frm_d   = ferr_now;
            brk_d   = ferr_now & ~(|shift_q) & ((PARITY_MODE == PAR_NONE) | ~par_q);
            ferr_d  = 1'b0;
            state_d = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            idx_d  = idx_q + IW'(1);
            ferr_d = ferr_now;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      ferr_q   <= 1'b0;
      settle_q <= 2'b00;
      arm_q    <= 1'b0;
      dv_q     <= 1'b0;
      byte_q   <= '0;
      perr_q   <= 1'b0;
      frm_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      ferr_q   <= ferr_d;
      settle_q <= settle_d;
      arm_q    <= arm_d;
      dv_q     <= dv_d;
      byte_q   <= byte_d;
      perr_q   <= perr_d;
      frm_q    <= frm_d;
      brk_q    <= brk_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = frm_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != ST_IDLE);
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clocks per serial bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0, parity type: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-005 i_Clock  in  1  single clock; all logic on its rising edge.
REQ-006 i_Rst_L  in  1  reset, synchronous, active-low.
REQ-007 i_Rx_Serial  in  1  asynchronous serial line; idle high.
REQ-008 o_Rx_DV  out  1  one-cycle pulse; frame complete.
REQ-009 o_Rx_Byte  out  DATA_BITS  received data, LSB first on the line.
REQ-010 o_Parity_Err  out  1  parity mismatch on the last frame.
REQ-011 o_Frame_Err  out  1  a stop bit was sampled low on the last frame.
REQ-012 o_Break  out  1  last frame had all data bits 0, parity 0 (if enabled) and a framing error.
REQ-013 o_Busy  out  1  high in every state except IDLE.

Function
REQ-014 i_Rx_Serial shall pass through a two-flop synchronizer; all sampling uses the second flop (2-cycle input latency).
REQ-015 States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Encoding comes from the package.
REQ-016 IDLE: clear the counter and bit index; go to START when the synced line is 0.
REQ-017 START: count to (CLKS_PER_BIT-1)/2. If the line is still 0, clear the counter and go to DATA; otherwise treat it as a glitch and return to IDLE with no DV.
REQ-018 DATA: sample each bit after CLKS_PER_BIT further clocks, i.e. at bit centre. Store into o_Rx_Byte[index]. After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else go to STOP.
REQ-019 PARITY: sample one bit at bit centre. Error when (XOR of data ^ parity bit) ≠ 0 for even mode, or ≠ 1 for odd mode.
REQ-020 STOP: sample STOP_BITS bits at bit centre. Any 0 sample sets the frame-error condition.
REQ-021 o_Rx_DV shall pulse for exactly one cycle, on the cycle after the last stop-bit sample (mid-bit, not end-of-bit). o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break update on that same cycle.
REQ-022 o_Rx_Byte and all error/break flags hold their values until the next o_Rx_DV.
REQ-023 o_Rx_Byte updates only at DV time; in-flight bits go to an internal shift register, not directly to the output.
REQ-024 After the DV cycle: no frame error → go to IDLE; frame error → go to WAIT_IDLE, which holds until the synced line is 1, then goes to IDLE. A held-low break therefore yields one DV only.
REQ-025 Back-to-back frames: a start edge arriving half a bit after the stop sample shall be received with no frame lost.
REQ-026 PARITY_MODE=0 forces o_Parity_Err to 0; o_Break then ignores parity.
REQ-027 Counter width is $clog2(CLKS_PER_BIT) bits. The counter shall never wrap inside a bit period.
REQ-028 Bit-index width is $clog2(DATA_BITS+1) bits.

Reset
REQ-029 While i_Rst_L=0 at a clock edge:
- state → IDLE
- counter and index → 0
- synchronizer flops → 1
- o_Rx_DV, o_Parity_Err, o_Frame_Err, o_Break, o_Busy → 0
- o_Rx_Byte → 0
REQ-030 Reset asserted mid-frame shall abort the frame with no DV. Reception restarts only on a fresh falling edge after reset release.

Structure
REQ-031 Shared package uart_pkg shall hold the state enum and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), for reuse by the parametrised transmitter.
REQ-032 The two-flop synchronizer shall be a sub-module named uart_sync2 (reset value 1).
REQ-033 Illegal parameter values shall be rejected at elaboration.

Verification (CLKS_PER_BIT=87, 100 ns clock, bit period 8700 ns)
REQ-034 8N1, send 0x3F → one DV pulse; o_Rx_Byte=0x3F; all error flags 0; DV occurs about 9.5 bit periods after the start edge.
REQ-035 DATA_BITS=8, even parity, 2 stop bits: send 0xA5 with parity 0 → DV, no errors. Send 0xA5 with parity 1 → o_Parity_Err=1, byte 0xA5.
REQ-036 8N1, 40-clock low glitch while idle → no DV, returns to IDLE. A following valid 0x55 is received correctly.
REQ-037 8N1, line held low for 30 bit periods → exactly one DV with byte 0x00, o_Frame_Err=1, o_Break=1, o_Busy high until the line returns high. A following 0x81 is received with no errors.
REQ-038 8N1, frames 0x12, 0x34, 0x56 back-to-back, each start edge half a bit after the prior stop sample → three DVs with the correct bytes.
REQ-039 i_Rst_L pulsed low during bit 4 of a frame → no DV, all outputs 0. The next full frame 0xC3 is received correctly.
